mac_seq_tx: RTL and testbench

MAC_SEQ_TX -- requirements
Module: mac_seq_tx

---
 rtl/mac_seq_pkg.sv | 20 ++
 rtl/mac_seq_tx.sv | 107 ++++++++++
 tb/tb_mac_seq_tx.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_seq_pkg.sv
// Shared types and constants for the MAC sequencing transmitter.
// Holds the FSM state encoding, the response error codes and parameter defaults.
package mac_seq_pkg;

  localparam int DW_DEF  = 32;
  localparam int TMO_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    BEAT_A,
    BEAT_B,
    BEAT_C,
    WAIT_RSP
  } state_t;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISMATCH = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

endpackage

// File: rtl/mac_seq_tx.sv
// Sends an operand triplet as three consecutive beats to a MAC datapath, then
// checks the returned result against a locally computed a*b+c, with timeout.
module mac_seq_tx
  import mac_seq_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int TMO = TMO_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [DW-1:0] cmd_a,
  input  logic [DW-1:0] cmd_b,
  input  logic [DW-1:0] cmd_c,
  output logic          validi,
  output logic [DW-1:0] data_in,
  input  logic          valido,
  input  logic [DW-1:0] data_out,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic [1:0]    rsp_err
);

  localparam int CW = (TMO > 2) ? $clog2(TMO) : 1;
  // The timeout pulse lands TMO cycles after the BEAT_C cycle, so the final
  // decision is taken at the end of WAIT_RSP cycle number TMO-1.
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO - 2);

  state_t        state;
  logic [CW-1:0] tmo_cnt;
  logic [DW-1:0] b_q;
  logic [DW-1:0] c_q;
  logic [DW-1:0] exp_q;

  // NOTE: every register here is written with <= so all of them see the
  // values from before the edge; mixing in = would reorder the update.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      b_q       <= '0;
      c_q       <= '0;
      exp_q     <= '0;
      cmd_ready <= 1'b1;
      validi    <= 1'b0;
      data_in   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= ERR_OK;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            b_q       <= cmd_b;
            c_q       <= cmd_c;
            exp_q     <= cmd_a * cmd_b + cmd_c;
            cmd_ready <= 1'b0;
            validi    <= 1'b1;
            data_in   <= cmd_a;
            state     <= BEAT_A;
          end else begin
            // Ready re-opens one cycle after the response pulse.
            cmd_ready <= 1'b1;
          end
        end
        BEAT_A: begin
          data_in <= b_q;
          state   <= BEAT_B;
        end
        BEAT_B: begin
          data_in <= c_q;
          state   <= BEAT_C;
        end
        BEAT_C: begin
          validi  <= 1'b0;
          data_in <= '0;
          tmo_cnt <= '0;
          state   <= WAIT_RSP;
        end
        WAIT_RSP: begin
          if (valido) begin
            rsp_valid <= 1'b1;
            rsp_data  <= data_out;
            rsp_err   <= (data_out == exp_q) ? ERR_OK : ERR_MISMATCH;
            state     <= IDLE;
          end else if (tmo_cnt == TMO_LAST) begin
            rsp_valid <= 1'b1;
            rsp_data  <= '0;
            rsp_err   <= ERR_TIMEOUT;
            state     <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end
        default: begin
          validi    <= 1'b0;
          data_in   <= '0;
          cmd_ready <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_seq_tx.sv
// Self-checking bench for mac_seq_tx: beat sequencing, result checking,
// timeout, reset behaviour and back-to-back command flow.
module tb_mac_seq_tx;

  localparam int DW = 32;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    err;
    int            cyc;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [DW-1:0] cmd_a = '0;
  logic [DW-1:0] cmd_b = '0;
  logic [DW-1:0] cmd_c = '0;
  logic          validi;
  logic [DW-1:0] data_in;
  logic          valido = 1'b0;
  logic [DW-1:0] data_out = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic [1:0]    rsp_err;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fails = 0;
  rsp_t sb[$];

  mac_seq_tx #(.DW(DW), .TMO(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_c     (cmd_c),
    .validi    (validi),
    .data_in   (data_in),
    .valido    (valido),
    .data_out  (data_out),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor: every rsp_valid pulse must match the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (rst && rsp_valid) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fails++;
        $display("FAIL unexpected_rsp cyc=%0d data=%h err=%b", cyc, rsp_data, rsp_err);
      end else begin
        rsp_t e;
        e = sb.pop_front();
        if (rsp_data !== e.data || rsp_err !== e.err || cyc !== e.cyc) begin
          n_fails++;
          $display("FAIL rsp got data=%h err=%b cyc=%0d, want data=%h err=%b cyc=%0d",
                   rsp_data, rsp_err, cyc, e.data, e.err, e.cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Handshake, check the three beats, then play the MAC model.
  // delay < 0: never answer; noise: wiggle valido during the beats.
  // Returns in the cycle where rsp_valid is expected (delay 0 or timeout).
  task automatic run_txn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] c, input int delay,
                         input logic [DW-1:0] rdata, input logic hold,
                         input logic noise, output int cyc_a);
    logic [DW-1:0] ops[3];
    logic [DW-1:0] model;
    rsp_t          e;
    int            n;
    ops[0] = a; ops[1] = b; ops[2] = c;
    model  = a * b + c;
    cyc_a  = -1;
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_c = c;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fails++;
      $display("FAIL ready_wait cmd_ready=%b after %0d cycles, want 1", cmd_ready, n);
      cmd_valid = 1'b0;
      return;
    end
    step();
    cyc_a = cyc;
    cmd_valid = hold;
    cmd_a = $urandom; cmd_b = $urandom; cmd_c = $urandom;
    if (delay < 0) begin
      e.data = '0; e.err = 2'b10; e.cyc = cyc_a + 6;
    end else begin
      e.data = rdata; e.err = (rdata == model) ? 2'b00 : 2'b01; e.cyc = cyc_a + 4 + delay;
    end
    sb.push_back(e);
    for (int i = 0; i < 3; i++) begin
      valido = noise; data_out = model;
      n_checks++;
      if (validi !== 1'b1 || data_in !== ops[i]) begin
        n_fails++;
        $display("FAIL beat%0d got validi=%b data_in=%h, want 1 %h", i, validi, data_in, ops[i]);
      end
      step();
    end
    valido = 1'b0; data_out = $urandom;
    n_checks++;
    if (validi !== 1'b0 || data_in !== '0) begin
      n_fails++;
      $display("FAIL wait_idle_bus got validi=%b data_in=%h, want 0 0", validi, data_in);
    end
    if (delay < 0) begin
      repeat (3) step();
    end else begin
      repeat (delay) step();
      valido = 1'b1; data_out = rdata;
      step();
      valido = 1'b0; data_out = $urandom;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) step();
    n_checks++;
    if (validi !== 1'b0 || data_in !== '0 || rsp_valid !== 1'b0 ||
        rsp_data !== '0 || rsp_err !== 2'b00) begin
      n_fails++;
      $display("FAIL reset_outputs got validi=%b data_in=%h rsp_valid=%b rsp_data=%h rsp_err=%b, want all 0",
               validi, data_in, rsp_valid, rsp_data, rsp_err);
    end
    rst = 1'b1;
    step();
    n_checks++;
    if (cmd_ready !== 1'b1 || validi !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_release got cmd_ready=%b validi=%b, want 1 0", cmd_ready, validi);
    end
  endtask

  task automatic test_nominal();
    int ca;
    run_txn(32'd3, 32'd4, 32'd5, 0, 32'd17, 1'b0, 1'b0, ca);
    n_checks++;
    if (cmd_ready !== 1'b0) begin
      n_fails++;
      $display("FAIL ready_in_rsp_cycle got %b, want 0", cmd_ready);
    end
    step();
  endtask

  task automatic test_wrap();
    int ca;
    run_txn(32'hFFFF_FFFF, 32'd2, 32'd3, 0, 32'd1, 1'b0, 1'b0, ca);
    step();
  endtask

  task automatic test_mismatch();
    int ca;
    run_txn(32'd2, 32'd2, 32'd2, 0, 32'd7, 1'b0, 1'b0, ca);
    step();
  endtask

  task automatic test_timeout();
    int ca;
    run_txn(32'd1, 32'd1, 32'd1, -1, '0, 1'b0, 1'b0, ca);
    step();
  endtask

  // Late answer, with valido pulsing during the beats where it must be ignored.
  task automatic test_late_rsp();
    int ca;
    run_txn(32'd1000, 32'd3000, 32'd77, 1, 32'd3_000_077, 1'b0, 1'b1, ca);
    step();
  endtask

  task automatic test_reset_mid();
    int n;
    cmd_valid = 1'b1; cmd_a = 32'd9; cmd_b = 32'd10; cmd_c = 32'd11;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    step();
    cmd_valid = 1'b0;
    step();
    n_checks++;
    if (validi !== 1'b1 || data_in !== 32'd10) begin
      n_fails++;
      $display("FAIL beat_b_before_rst got validi=%b data_in=%h, want 1 %h", validi, data_in, 32'd10);
    end
    rst = 1'b0;
    step();
    n_checks++;
    if (validi !== 1'b0 || data_in !== '0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fails++;
      $display("FAIL abort got validi=%b data_in=%h cmd_ready=%b rsp_valid=%b, want 0 0 1 0",
               validi, data_in, cmd_ready, rsp_valid);
    end
    n_checks++;
    if (rsp_data !== '0 || rsp_err !== 2'b00) begin
      n_fails++;
      $display("FAIL abort_rsp_regs got rsp_data=%h rsp_err=%b, want 0 00", rsp_data, rsp_err);
    end
    cmd_valid = 1'b1;
    step();
    n_checks++;
    if (validi !== 1'b0) begin
      n_fails++;
      $display("FAIL hs_in_reset got validi=%b, want 0", validi);
    end
    rst = 1'b1; cmd_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      valido = 1'b1; data_out = $urandom;
      step();
      n_checks++;
      if (validi !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
        n_fails++;
        $display("FAIL idle_after_abort got validi=%b rsp_valid=%b cmd_ready=%b, want 0 0 1",
                 validi, rsp_valid, cmd_ready);
      end
    end
    valido = 1'b0;
  endtask

  task automatic test_back_to_back();
    int ca1, ca2, rsp_cyc;
    run_txn(32'd6, 32'd7, 32'd8, 0, 32'd50, 1'b1, 1'b0, ca1);
    rsp_cyc = cyc;
    n_checks++;
    if (cmd_ready !== 1'b0 || validi !== 1'b0) begin
      n_fails++;
      $display("FAIL b2b_rsp_cycle got cmd_ready=%b validi=%b, want 0 0", cmd_ready, validi);
    end
    step();
    n_checks++;
    if (validi !== 1'b0) begin
      n_fails++;
      $display("FAIL b2b_gap got validi=%b, want 0", validi);
    end
    run_txn(32'd100, 32'd200, 32'd300, 0, 32'd20_300, 1'b0, 1'b0, ca2);
    n_checks++;
    if (ca2 < rsp_cyc + 2 || ca2 - (ca1 + 2) < 2) begin
      n_fails++;
      $display("FAIL b2b_spacing got beat_a2=%0d, want >= %0d", ca2, rsp_cyc + 2);
    end
    step();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      step();
      n++;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fails++;
      $display("FAIL drain got %0d outstanding responses, want 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_wrap();
    test_mismatch();
    test_timeout();
    test_late_rsp();
    test_reset_mid();
    test_back_to_back();
    drain();
    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
